// File: rtl/enable_counter.sv
// ---------------------------------------------------------------------------
// enable_counter
//
// Modulo up/down counter with count enable, synchronous clear and parallel
// load. The count wraps modulo MAX_VAL+1 in both directions. A combinational
// terminal-count output flags the cycle whose next edge will wrap, so
// counters can be cascaded.
//
// Parameters:
//   WIDTH    width of the count register and of i_din / o_q
//   MAX_VAL  terminal (wrap) value, legal range 1 .. 2**WIDTH-1
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous reset, active-high (highest priority)
//   i_en     count enable, one step per clock while high
//   i_clr    synchronous clear to 0
//   i_load   synchronous parallel load of i_din (clamped to MAX_VAL)
//   i_din    load value
//   i_dir    count direction, 1 = up, 0 = down
//   o_q      registered count value
//   o_tc     terminal count (combinational)
//   o_ovf    sticky wrap flag, present only when COUNTER_OVF_FLAG_EN is
//            defined; set on any enabled wrap, cleared by reset or clear
//
// Build option:
//   COUNTER_OVF_FLAG_EN  adds the o_ovf port and its flag register
// ---------------------------------------------------------------------------
module enable_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (2**WIDTH) - 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc
`ifdef COUNTER_OVF_FLAG_EN
  ,
  output logic             o_ovf
`endif
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_q_sat;
  logic [WIDTH-1:0] w_din_clamp;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_step;
  logic             w_wrap;

  // A count above MAX_VAL (only reachable through X-propagation when
  // MAX_VAL < 2**WIDTH-1) is treated as MAX_VAL by the next step.
  assign w_at_max    = (r_q >= LP_MAX);
  assign w_at_zero   = (r_q == '0);
  assign w_q_sat     = w_at_max ? LP_MAX : r_q;
  assign w_din_clamp = (i_din > LP_MAX) ? LP_MAX : i_din;

  // A step happens only when no higher-priority action owns the edge.
  assign w_step = i_en & ~i_rst & ~i_clr & ~i_load;
  assign w_wrap = w_step & (i_dir ? w_at_max : w_at_zero);

  always_comb begin
    w_q_nxt = r_q;
    if (i_clr) begin
      w_q_nxt = '0;
    end else if (i_load) begin
      w_q_nxt = w_din_clamp;
    end else if (i_en) begin
      if (i_dir) begin
        w_q_nxt = w_at_max ? '0 : (r_q + WIDTH'(1));
      end else begin
        w_q_nxt = w_at_zero ? LP_MAX : (w_q_sat - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign o_q  = r_q;
  assign o_tc = w_wrap;

`ifdef COUNTER_OVF_FLAG_EN
  logic r_ovf;

  // Load deliberately leaves the flag alone; only reset and clear drop it.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_enable_counter.sv
module tb_enable_counter;

  logic       clk;
  logic       rst, en, clr, load, dir;
  logic [3:0] din;
  logic [3:0] q15, q9;
  logic       tc15, tc9;
`ifdef COUNTER_OVF_FLAG_EN
  logic       ovf15, ovf9;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state for both instances.
  int m15, m9;
  bit mo15, mo9;

  typedef struct {
    bit rst, clr, load, en, dir;
    int din;
    bit tc15; int q15;
    bit tc9;  int q9;
  } vec_t;

  vec_t vecs[$];

  enable_counter #(.WIDTH(4)) dut15 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load),
    .i_din(din), .i_dir(dir), .o_q(q15), .o_tc(tc15)
`ifdef COUNTER_OVF_FLAG_EN
    , .o_ovf(ovf15)
`endif
  );

  enable_counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_load(load),
    .i_din(din), .i_dir(dir), .o_q(q9), .o_tc(tc9)
`ifdef COUNTER_OVF_FLAG_EN
    , .o_ovf(ovf9)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(bit r, bit c, bit l, bit e, bit d, int dn,
                              bit t15, int e15, bit t9, int e9);
    vec_t v;
    v.rst = r; v.clr = c; v.load = l; v.en = e; v.dir = d; v.din = dn;
    v.tc15 = t15; v.q15 = e15; v.tc9 = t9; v.q9 = e9;
    return v;
  endfunction

  // Modulo arithmetic view of the counter rules.
  function automatic int model_next(int q, int mx, bit r, bit c, bit l,
                                    bit e, bit d, int dn);
    if (r || c) return 0;
    if (l)      return (dn > mx) ? mx : dn;
    if (e)      return d ? (q + 1) % (mx + 1) : (q + mx) % (mx + 1);
    return q;
  endfunction

  function automatic bit model_wraps(int q, int mx, bit r, bit c, bit l,
                                     bit e, bit d);
    return !r && !c && !l && e && ((d && q == mx) || (!d && q == 0));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, check q/ovf after.
  // use_tab selects table expectations; otherwise the model supplies them.
  task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
    bit w15, w9;
    rst = v.rst; clr = v.clr; load = v.load; en = v.en; dir = v.dir;
    din = 4'(v.din);
    w15 = model_wraps(m15, 15, v.rst, v.clr, v.load, v.en, v.dir);
    w9  = model_wraps(m9,  9,  v.rst, v.clr, v.load, v.en, v.dir);
    @(negedge clk);
    chk({tag, " tc15"}, int'(tc15), use_tab ? int'(v.tc15) : int'(w15));
    chk({tag, " tc9"},  int'(tc9),  use_tab ? int'(v.tc9)  : int'(w9));
    @(posedge clk);
    m15 = model_next(m15, 15, v.rst, v.clr, v.load, v.en, v.dir, v.din);
    m9  = model_next(m9,  9,  v.rst, v.clr, v.load, v.en, v.dir, v.din);
    mo15 = (v.rst || v.clr) ? 1'b0 : (mo15 | w15);
    mo9  = (v.rst || v.clr) ? 1'b0 : (mo9  | w9);
    #1;
    chk({tag, " q15"}, int'(q15), use_tab ? v.q15 : m15);
    chk({tag, " q9"},  int'(q9),  use_tab ? v.q9  : m9);
`ifdef COUNTER_OVF_FLAG_EN
    chk({tag, " ovf15"}, int'(ovf15), int'(mo15));
    chk({tag, " ovf9"},  int'(ovf9),  int'(mo9));
`endif
  endtask

  initial begin
    vec_t rv;

    //              rst clr ld en dir din | tc15 q15 | tc9 q9   (start q=9/9)
    vecs.push_back(mk(0, 0, 1, 1, 1, 14,   0, 14,   0, 9));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,    0, 15,   1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,    1, 0,    0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,    0, 1,    0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1,    0, 1,    0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,    0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,    1, 15,   1, 9));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,    0, 14,   0, 8));
    vecs.push_back(mk(0, 0, 1, 1, 1, 7,    0, 7,    0, 7));
    vecs.push_back(mk(0, 0, 1, 1, 1, 12,   0, 12,   0, 9));
    vecs.push_back(mk(0, 1, 1, 1, 0, 7,    0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5,    0, 5,    0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,    0, 5,    0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 5,    0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,    0, 5,    0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0, 5,    0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,    0, 5,    0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 0, 6,    0, 6,    0, 6));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0,    0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,    0, 1,    0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 15,   0, 15,   0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,    0, 15,   0, 9));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0,    0, 0,    0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3,    0, 3,    0, 3));

    // Reset sequence: rst high 0..12, counting up from the start.
    rst = 1'b1; en = 1'b1; dir = 1'b1; clr = 1'b0; load = 1'b0; din = 4'd0;
    #10;
    chk("reset q15", int'(q15), 0);
    chk("reset q9",  int'(q9),  0);
    chk("reset tc15", int'(tc15), 0);
`ifdef COUNTER_OVF_FLAG_EN
    chk("reset ovf15", int'(ovf15), 0);
    chk("reset ovf9",  int'(ovf9),  0);
`endif
    #2 rst = 1'b0;
    #8;
    chk("first step q15", int'(q15), 1);
    chk("first step q9",  int'(q9),  1);
    #76;
    chk("t95 q15", int'(q15), 9);
    chk("t95 q9",  int'(q9),  9);
    m15 = 9; m9 = 9; mo15 = 1'b0; mo9 = 1'b0;

    foreach (vecs[i]) begin
      run_cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Random traffic against the model; control actions kept infrequent so
    // that both instances wrap repeatedly in each direction.
    for (int k = 0; k < 400; k++) begin
      rv.rst  = ($urandom_range(0, 49) == 0);
      rv.clr  = ($urandom_range(0, 29) == 0);
      rv.load = ($urandom_range(0, 11) == 0);
      rv.en   = ($urandom_range(0, 3) != 0);
      rv.dir  = ($urandom_range(0, 9) < ((k / 50) % 2 == 0 ? 8 : 2));
      rv.din  = int'($urandom_range(0, 15));
      rv.tc15 = 1'b0; rv.q15 = 0; rv.tc9 = 1'b0; rv.q9 = 0;
      run_cycle(rv, 1'b0, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
